// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between NCPU cores, each with an
// instruction port and a data port; data beats instruction within a core.
module ram_arbiter #(
    parameter int NCPU    = 2,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                                   CLK,
    input  logic                                   nRST,
    input  logic [NCPU-1:0]                        iREN,
    input  logic [NCPU-1:0]                        dREN,
    input  logic [NCPU-1:0]                        dWEN,
    input  logic [NCPU*WORD_W-1:0]                 iaddr,
    input  logic [NCPU*WORD_W-1:0]                 daddr,
    input  logic [NCPU*WORD_W-1:0]                 dstore,
    output logic [NCPU-1:0]                        iwait,
    output logic [NCPU-1:0]                        dwait,
    output logic [NCPU*WORD_W-1:0]                 iload,
    output logic [NCPU*WORD_W-1:0]                 dload,
    output logic [WORD_W-1:0]                      ramaddr,
    output logic [WORD_W-1:0]                      ramstore,
    output logic                                   ramREN,
    output logic                                   ramWEN,
    input  logic [WORD_W-1:0]                      ramload,
    input  logic [1:0]                             ramstate,
    output logic [((NCPU > 1) ? $clog2(NCPU) : 1)-1:0] grant_id,
    output logic                                   err_sticky
);

    localparam int IDW = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE, GRANT} state_t;
    typedef enum logic {SRC_I, SRC_D} src_t;

    state_t          state, state_nxt;
    src_t            source, source_nxt;
    logic [IDW-1:0]  owner, owner_nxt;
    logic [IDW-1:0]  rr, rr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            err_nxt;
    logic [NCPU-1:0] pending;
    logic            sel_req;
    logic            access;

    assign pending = iREN | dREN | dWEN;
    assign sel_req = (source == SRC_D) ? (dREN[owner] | dWEN[owner]) : iREN[owner];
    assign access  = (state == GRANT) && sel_req && (ramstate == RAM_ACCESS);

    assign iload = {NCPU{ramload}};
    assign dload = {NCPU{ramload}};

    // RAM-side strobes follow the owner's live request; a simultaneous
    // read and write on the data port is serviced as a write.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        grant_id = '0;
        if (state == GRANT) begin
            grant_id = owner;
            if (source == SRC_D) begin
                ramWEN   = dWEN[owner];
                ramREN   = dREN[owner] & ~dWEN[owner];
                ramaddr  = daddr[owner*WORD_W +: WORD_W];
                ramstore = dstore[owner*WORD_W +: WORD_W];
            end else begin
                ramREN  = iREN[owner];
                ramaddr = iaddr[owner*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        iwait = iREN;
        dwait = dREN | dWEN;
        if (access) begin
            if (source == SRC_D) dwait[owner] = 1'b0;
            else                 iwait[owner] = 1'b0;
        end
    end

    always_comb begin
        logic found;
        int   j;
        state_nxt  = state;
        owner_nxt  = owner;
        source_nxt = source;
        rr_nxt     = rr;
        cnt_nxt    = cnt;
        err_nxt    = err_sticky;
        found      = 1'b0;
        j          = 0;
        case (state)
            IDLE: begin
                for (int i = 0; i < NCPU; i++) begin
                    j = int'(rr) + i;
                    if (j >= NCPU) j = j - NCPU;
                    if (!found && pending[j]) begin
                        found      = 1'b1;
                        owner_nxt  = IDW'(j);
                        source_nxt = (dREN[j] | dWEN[j]) ? SRC_D : SRC_I;
                    end
                end
                if (found) state_nxt = GRANT;
            end
            GRANT: begin
                if (!sel_req) begin
                    // Withdrawn request: release without advancing fairness.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (ramstate == RAM_ACCESS) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rr_nxt    = (owner == IDW'(NCPU - 1)) ? '0 : owner + 1'b1;
                end else begin
                    if (cnt != CW'(TIMEOUT)) cnt_nxt = cnt + 1'b1;
                    if (cnt_nxt == CW'(TIMEOUT)) err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            owner      <= '0;
            source     <= SRC_I;
            rr         <= '0;
            cnt        <= '0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            source     <= source_nxt;
            rr         <= rr_nxt;
            cnt        <= cnt_nxt;
            err_sticky <= err_nxt;
        end
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NCPU, default 2, number of cores sharing RAM (1..8).
REQ-002 SHALL have parameter WORD_W, default 32, address and data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum GRANT cycles before the error flag sets.
REQ-004 SHALL have port CLK  in  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port nRST  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports iREN, dREN, dWEN  in  NCPU  per-core instruction read, data read and data write requests.
REQ-007 SHALL have ports iaddr, daddr, dstore  in  NCPU*WORD_W  per-core addresses and write data; core k occupies bits [k*WORD_W +: WORD_W].
REQ-008 SHALL have ports iwait, dwait  out  NCPU  per-core stall, high while a request is not yet serviced.
REQ-009 SHALL have ports iload, dload  out  NCPU*WORD_W  per-core read data.
REQ-010 SHALL have ports ramaddr, ramstore  out  WORD_W  RAM address and write data.
REQ-011 SHALL have ports ramREN, ramWEN  out  1  RAM read and write strobes.
REQ-012 SHALL have ports ramload  in  WORD_W, ramstate  in  2: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-013 SHALL have ports grant_id  out  clog2(NCPU) (min 1)  current owner; err_sticky  out  1  timeout seen.

Function
REQ-014 SHALL have FSM states IDLE and GRANT; registers: state, owner, source (I/D), rr pointer, timeout counter, err_sticky.
REQ-015 Core k SHALL be pending when iREN[k]|dREN[k]|dWEN[k].
REQ-016 In IDLE, arbitration SHALL pick the first pending core searching rr, rr+1, ... modulo NCPU; the next edge latches owner and enters GRANT.
REQ-017 Within the winning core, the data port SHALL win over the instruction port; source SHALL be latched with owner.
REQ-018 If dWEN and dREN are both high on one port, the access SHALL be treated as a write.
REQ-019 In GRANT, ramaddr, ramstore, ramREN and ramWEN SHALL be driven combinationally from the live signals of owner/source; in IDLE, ramREN=ramWEN=0 and ramaddr=ramstore=0.
REQ-020 iload and dload SHALL all equal ramload, broadcast to every core.
REQ-021 Every wait bit SHALL be 1 while its port is requesting, except the owner/source bit in a GRANT cycle with ramstate==ACCESS, which SHALL be 0.
REQ-022 On a GRANT cycle with ramstate==ACCESS, the next edge SHALL go to IDLE, set rr=(owner+1) mod NCPU and clear the counter.
REQ-023 Minimum service time SHALL be 2 cycles (IDLE arbitration plus GRANT with ACCESS); back-to-back grants are separated by one IDLE cycle.
REQ-024 BUSY and FREE in GRANT SHALL hold the grant; ERROR SHALL hold the grant and retry without completing.
REQ-025 If the owner's selected request drops during GRANT before ACCESS, the next edge SHALL go to IDLE with rr unchanged and no completion.
REQ-026 The counter SHALL increment each GRANT cycle without ACCESS and saturate at TIMEOUT; reaching TIMEOUT SHALL set err_sticky, which clears only on reset, and the grant SHALL continue.
REQ-027 With NCPU=1, rr SHALL remain 0 and behaviour otherwise be identical.
REQ-028 grant_id SHALL equal owner in GRANT and 0 in IDLE.

Reset
REQ-029 While nRST=0 at an edge: state=IDLE, owner=0, source=I, rr=0, counter=0, err_sticky=0.
REQ-030 Reset mid-GRANT SHALL abandon the transaction; ramREN=ramWEN=0 from the following cycle with no completion signalled.
REQ-031 After reset, outputs SHALL be ramREN=ramWEN=0, ramaddr=ramstore=0, grant_id=0, err_sticky=0, and wait bits SHALL equal the request inputs.

Verification
REQ-032 Single read: core0 dREN=1, daddr=0x40, RAM ACCESS on first GRANT cycle, ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 in cycle 2; dwait[0]=0 and dload=0xDEADBEEF in cycle 2; IDLE in cycle 3; rr=1.
REQ-033 Fairness: NCPU=2, both cores dREN continuously, ACCESS immediate -> grants alternate 0,1,0,1; no core waits more than 4 cycles.
REQ-034 Priority: core1 iREN and dWEN together, dstore=0x1234 -> write serviced first (ramWEN=1, ramstore=0x1234), then the instruction read on the next grant.
REQ-035 Timeout: TIMEOUT=4, ramstate held BUSY -> err_sticky=1 after 4 GRANT cycles, grant held; ACCESS then completes normally; err_sticky stays 1.
REQ-036 Withdrawal and reset: drop dREN mid-GRANT -> IDLE, rr unchanged; assert nRST=0 mid-GRANT -> ramREN=0 next cycle, rr=0.
